// File: rtl/counter_sched_pkg.sv
// Shared types and enable encodings for the counter command scheduler.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXEC   = 2'b01,
        SETTLE = 2'b10,
        RESP   = 2'b11
    } state_e;

    // {load_en, count_en}; the counter decrements when both are low.
    localparam logic [1:0] EN_LOAD = 2'b10;
    localparam logic [1:0] EN_UP   = 2'b01;
    localparam logic [1:0] EN_DOWN = 2'b00;
    localparam logic [1:0] EN_HOLD = 2'b11;

    function automatic logic [1:0] op_enables(op_e op);
        case (op)
            OP_LOAD: op_enables = EN_LOAD;
            OP_UP:   op_enables = EN_UP;
            OP_DOWN: op_enables = EN_DOWN;
            default: op_enables = EN_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester-facing bundle of the counter scheduler: command handshake, completion and status.
interface counter_sched_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    localparam int IW = $clog2(NREQ);

    // Requester i transfers a command on a rising edge where req_valid[i] & req_ready[i];
    // req_ready is one-hot, and op/arg of slice i only need to be stable on that edge.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_arg;
    logic                  done_valid;
    logic [IW-1:0]         done_id;
    logic [WIDTH-1:0]      done_value;
    logic                  done_even;
    logic                  busy;
    logic [1:0]            state;

    modport master (
        output req_valid, req_op, req_arg,
        input  req_ready, done_valid, done_id, done_value, done_even, busy, state
    );

    modport slave (
        input  req_valid, req_op, req_arg,
        output req_ready, done_valid, done_id, done_value, done_even, busy, state
    );

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr (wrapping) for the first request.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);
    localparam int IW = $clog2(NREQ);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = IW'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Shares one up/down/load counter among NREQ requesters: round-robin accept, drive the
// counter enables for the command's step count, then report the settled count.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             reset,
    counter_sched_if.slave   bus,
    output logic             load_en,
    output logic             count_en,
    output logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] sys_out,
    input  logic             out_even
);
    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_EXEC   = EXEC;
    localparam logic [1:0] S_SETTLE = SETTLE;
    localparam logic [1:0] S_RESP   = RESP;

    logic [1:0]       state;
    logic [WIDTH-1:0] steps;
    op_e              op_q;
    logic [WIDTH-1:0] arg_q;
    logic [IW-1:0]    id_q;
    logic [IW-1:0]    ptr;

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    win;
    logic             any_valid;
    logic             idle;
    logic             accept;
    op_e              sel_op;
    logic [WIDTH-1:0] sel_arg;
    logic [WIDTH-1:0] sel_steps;

    logic             done_valid_q;
    logic [IW-1:0]    done_id_q;
    logic [WIDTH-1:0] done_value_q;
    logic             done_even_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .found (any_valid)
    );

    assign idle   = (state == S_IDLE);
    // Reset outranks a pending request so nothing is accepted on a reset edge.
    assign accept = idle && !reset && any_valid;

    always_comb begin
        sel_op  = op_e'(bus.req_op[2*int'(win) +: 2]);
        sel_arg = bus.req_arg[WIDTH*int'(win) +: WIDTH];
        case (sel_op)
            OP_LOAD:        sel_steps = WIDTH'(1);
            OP_UP, OP_DOWN: sel_steps = sel_arg;
            default:        sel_steps = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            steps        <= '0;
            op_q         <= OP_NOP;
            arg_q        <= '0;
            id_q         <= '0;
            ptr          <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_value_q <= '0;
            done_even_q  <= 1'b0;
        end else begin
            done_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= sel_op;
                        arg_q <= sel_arg;
                        id_q  <= win;
                        steps <= sel_steps;
                        ptr   <= (int'(win) == NREQ - 1) ? '0 : win + IW'(1);
                        state <= (sel_steps != '0) ? S_EXEC : S_SETTLE;
                    end
                end
                S_EXEC: begin
                    if (steps <= WIDTH'(1)) state <= S_SETTLE;
                    else                    steps <= steps - WIDTH'(1);
                end
                S_SETTLE: begin
                    state        <= S_RESP;
                    done_valid_q <= 1'b1;
                    done_id_q    <= id_q;
                    done_value_q <= sys_out;
                    done_even_q  <= out_even;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // HOLD everywhere except EXEC; otherwise the counter would drift downward.
    assign {load_en, count_en} = (state == S_EXEC) ? op_enables(op_q) : EN_HOLD;
    assign data = (state == S_EXEC && op_q == OP_LOAD) ? arg_q : '0;

    assign bus.req_ready  = accept ? grant : '0;
    assign bus.busy       = !idle;
    assign bus.state      = state;
    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_value = done_value_q;
    assign bus.done_even  = done_even_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a transaction-level reference model and a counter stand-in.
module tb_counter_sched;
    localparam int WIDTH = 8;
    localparam int NREQ  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_en, count_en;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] cnt;
    logic             out_even;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_done = 0;
    bit started = 1'b0;

    counter_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    counter_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .load_en  (load_en),
        .count_en (count_en),
        .data     (data),
        .sys_out  (cnt),
        .out_even (out_even)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- counter arithmetic ----------------
    function automatic logic [7:0] up1(input logic [7:0] v);
        return (v >= 8'hFE) ? 8'h00 : v + 8'h01;
    endfunction

    function automatic logic [7:0] dn1(input logic [7:0] v);
        return (v <= 8'h01) ? 8'hFF : v - 8'h01;
    endfunction

    function automatic logic [7:0] apply(input logic [7:0] v, input int op, input logic [7:0] a);
        logic [7:0] r;
        r = v;
        case (op)
            0: r = a;
            1: for (int i = 0; i < int'(a); i++) r = up1(r);
            2: for (int i = 0; i < int'(a); i++) r = dn1(r);
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] pair(input int op);
        case (op)
            0: return 2'b10;
            1: return 2'b01;
            2: return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    // Counter stand-in driven by the scheduler's enables.
    always @(posedge clk) begin
        if (reset) cnt <= 8'h00;
        else begin
            case ({load_en, count_en})
                2'b10:   cnt <= data;
                2'b01:   cnt <= up1(cnt);
                2'b00:   cnt <= dn1(cnt);
                default: cnt <= cnt;
            endcase
        end
    end
    assign out_even = ~cnt[0];

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a command accepted in cycle a with s steps runs its enables in
    // cycles a+1..a+s, reports in cycle a+s+2, and the scheduler is free again after that.
    int          m_ptr, m_acc, m_done, m_s, m_op, m_id, m_did, w, j;
    logic [7:0]  m_arg, m_res, m_cnt, m_dv, exp_data;
    logic        m_deven;
    bit          in_cmd, in_exec;
    logic [1:0]  exp_en, exp_ready;
    logic [WIDTH-1:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.done_valid === 1'b1) n_done++;
        if (reset) begin
            if (started) check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            started = 1'b1;
            m_ptr = 0; m_acc = -1; m_done = -1; m_s = 0; m_op = 3; m_id = 0;
            m_cnt = 8'h00; m_dv = 8'h00; m_did = 0; m_deven = 1'b0; m_res = 8'h00;
            exp_q.delete();
        end else if (started) begin
            if (cyc == m_done) begin
                m_cnt   = m_res;
                m_dv    = exp_q.pop_front();
                m_did   = m_id;
                m_deven = ~m_dv[0];
            end
            in_cmd    = (m_done >= 0) && (cyc <= m_done);
            in_exec   = in_cmd && (cyc >= m_acc + 1) && (cyc <= m_acc + m_s);
            exp_en    = in_exec ? pair(m_op) : 2'b11;
            exp_data  = (in_exec && m_op == 0) ? m_arg : 8'h00;
            exp_ready = 2'b00;
            if (!in_cmd) begin
                check("idle_sys_out", 32'(cnt), 32'(m_cnt));
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (w < 0 && bus.req_valid[j]) w = j;
                end
                if (w >= 0) begin
                    exp_ready[w] = 1'b1;
                    m_acc = cyc;
                    m_id  = w;
                    m_op  = int'(bus.req_op[2*w +: 2]);
                    m_arg = bus.req_arg[WIDTH*w +: WIDTH];
                    m_s   = (m_op == 0) ? 1 : (m_op == 3) ? 0 : int'(m_arg);
                    m_res = apply(m_cnt, m_op, m_arg);
                    exp_q.push_back(m_res);
                    m_done = cyc + m_s + 2;
                    m_ptr  = (w + 1) % NREQ;
                end
            end
            check("req_ready",  32'(bus.req_ready), 32'(exp_ready));
            check("busy",       32'(bus.busy), 32'(in_cmd));
            check("enables",    32'({load_en, count_en}), 32'(exp_en));
            check("data",       32'(data), 32'(exp_data));
            check("done_valid", 32'(bus.done_valid), 32'(cyc == m_done));
            check("done_id",    32'(bus.done_id), 32'(m_did));
            check("done_value", 32'(bus.done_value), 32'(m_dv));
            check("done_even",  32'(bus.done_even), 32'(m_deven));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int id, input int op, input logic [7:0] arg, output int t);
        bit ok;
        logic [1:0] opb;
        opb = 2'(op);
        @(posedge clk); #1;
        bus.req_op[2*id +: 2]         = opb;
        bus.req_arg[WIDTH*id +: WIDTH] = arg;
        bus.req_valid[id]              = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req_ready[id] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        t = cyc;
        check("accept_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    // Waits for the next done pulse; also counts cycles whose enables were not HOLD.
    task automatic wait_done(output int td, output int n_active);
        bit ok;
        ok = 1'b0;
        n_active = 0;
        td = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ({load_en, count_en} != 2'b11) n_active++;
            if (bus.done_valid === 1'b1) begin
                ok = 1'b1;
                td = cyc;
                break;
            end
        end
        check("done_seen", 32'(ok), 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t, td, na, prev, base;
        bus.req_valid = '0;
        bus.req_op    = '1;
        bus.req_arg   = '0;
        repeat (3) @(posedge clk);

        // Reset with a pending request: reset values, no accept.
        #1 bus.req_valid = 2'b01;
        @(negedge clk);
        check("rst_ready",      32'(bus.req_ready), 32'd0);
        check("rst_busy",       32'(bus.busy), 32'd0);
        check("rst_enables",    32'({load_en, count_en}), 32'h3);
        check("rst_data",       32'(data), 32'h0);
        check("rst_done_valid", 32'(bus.done_valid), 32'd0);
        check("rst_done_value", 32'(bus.done_value), 32'h0);
        check("rst_done_id",    32'(bus.done_id), 32'd0);
        check("rst_done_even",  32'(bus.done_even), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("no_accept_on_reset", 32'(bus.busy), 32'd0);

        // 1: LOAD 0x10 from req0.
        issue(0, 0, 8'h10, t);
        @(negedge clk);
        check("t1_load_enables", 32'({load_en, count_en}), 32'h2);
        check("t1_load_data",    32'(data), 32'h10);
        wait_done(td, na);
        check("t1_latency", 32'(td - t), 32'd3);
        check("t1_id",      32'(bus.done_id), 32'd0);
        check("t1_value",   32'(bus.done_value), 32'h10);
        check("t1_even",    32'(bus.done_even), 32'd1);

        // 2: LOAD 0xFC then UP 5 wraps through FE->00.
        issue(1, 0, 8'hFC, t);
        wait_done(td, na);
        issue(0, 1, 8'd5, t);
        wait_done(td, na);
        check("t2_up_cycles", 32'(na), 32'd5);
        check("t2_latency",   32'(td - t), 32'd7);
        check("t2_value",     32'(bus.done_value), 32'h02);
        check("t2_even",      32'(bus.done_even), 32'd1);

        // 3: LOAD 0x01 then DOWN 3 wraps through 01->FF.
        issue(1, 0, 8'h01, t);
        wait_done(td, na);
        issue(1, 2, 8'd3, t);
        wait_done(td, na);
        check("t3_down_cycles", 32'(na), 32'd3);
        check("t3_latency",     32'(td - t), 32'd5);
        check("t3_value",       32'(bus.done_value), 32'hFD);
        check("t3_even",        32'(bus.done_even), 32'd0);

        // 4: both requesters hold NOP; grants alternate starting at req0.
        @(posedge clk); #1;
        bus.req_op    = 4'b1111;
        bus.req_valid = 2'b11;
        prev = 0;
        for (int n = 0; n < 6; n++) begin
            wait_done(td, na);
            check("t4_done_id", 32'(bus.done_id), 32'(n % 2));
            if (n > 0) check("t4_spacing", 32'(td - prev), 32'd3);
            prev = td;
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);

        // 5: reset in the middle of UP 200 drops the command.
        base = n_done;
        issue(0, 1, 8'd200, t);
        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_busy",       32'(bus.busy), 32'd0);
        check("t5_enables",    32'({load_en, count_en}), 32'h3);
        check("t5_counter",    32'(cnt), 32'h00);
        check("t5_done_value", 32'(bus.done_value), 32'h00);
        repeat (200) @(posedge clk);
        check("t5_no_done", 32'(n_done - base), 32'd0);

        // 6: UP 0 and NOP skip EXEC and leave the value alone.
        issue(1, 1, 8'd0, t);
        wait_done(td, na);
        check("t6_up0_latency", 32'(td - t), 32'd2);
        check("t6_up0_active",  32'(na), 32'd0);
        check("t6_up0_value",   32'(bus.done_value), 32'h00);
        check("t6_up0_id",      32'(bus.done_id), 32'd1);
        issue(0, 3, 8'h55, t);
        wait_done(td, na);
        check("t6_nop_latency", 32'(td - t), 32'd2);
        check("t6_nop_value",   32'(bus.done_value), 32'h00);
        check("t6_nop_even",    32'(bus.done_even), 32'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
